// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state encoding, the stage-control bundle and the advance rule helper.
package pipeline_hazard_ctrl_pkg;

  localparam int MEM_TIMEOUT_DEF = 16;
  localparam int REG_W           = 3;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_MEM_WAIT,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
  } ctrl_t;

  // Stage enables once memory is not holding the pipe: branch beats load-use.
  function automatic ctrl_t advance(input logic branch_taken, input logic load_use);
    ctrl_t c;
    c = '{pc_write: 1'b1, if_id_write: 1'b1, id_ex_write: 1'b1, ex_mem_write: 1'b1,
          if_id_flush: 1'b0, id_ex_flush: 1'b0};
    if (branch_taken) begin
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (load_use) begin
      c.pc_write    = 1'b0;
      c.if_id_write = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_load_use_detect.sv
// Detects a load in EX whose destination feeds a source operand of the instruction in ID.
module load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_memread,
  output logic             load_use
);

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = id_ex_memread && (id_ex_rd != '0) &&
                    ((id_ex_rd == id_rs1) || (id_ex_rd == id_rs2));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/halt controller for a 5-stage pipeline: load-use, branch flush,
// data-memory wait with timeout fault, and WB halt.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic [REG_W-1:0] id_ex_rd,
  input  logic             id_ex_memread,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             wb_halt,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic             mem_timeout,
  output logic [15:0]      stall_cycles
);

  localparam int                WAIT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [15:0]       stall_q, stall_d;
  logic              timeout_q, timeout_d;
  logic              load_use;
  ctrl_t             ctrl;

  load_use_detect u_load_use_detect (
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .id_ex_rd      (id_ex_rd),
    .id_ex_memread (id_ex_memread),
    .load_use      (load_use)
  );

  always_comb begin
    ctrl       = '0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    timeout_d  = timeout_q;
    stall_d    = stall_q;

    case (state_q)
      ST_RUN: begin
        if (mem_req && !mem_ready) state_d = ST_MEM_WAIT;
        else                       ctrl    = advance(branch_taken, load_use);
      end
      ST_MEM_WAIT: begin
        if (!mem_ready) begin
          if (wait_cnt_q == WAIT_LAST) begin
            state_d   = ST_HALTED;
            timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          ctrl       = advance(branch_taken, load_use);
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      default: ;
    endcase

    // A HALT reaching WB wins over every other transition; this cycle's enables stand.
    if (wb_halt && state_q != ST_HALTED) state_d = ST_HALTED;

    if (state_q != ST_HALTED && !ctrl.pc_write && stall_q != 16'hFFFF)
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_RUN;
      wait_cnt_q <= '0;
      stall_q    <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      timeout_q  <= timeout_d;
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign id_ex_write  = ctrl.id_ex_write;
  assign ex_mem_write = ctrl.ex_mem_write;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign halted       = (state_q == ST_HALTED);
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_q;

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, default 16, max consecutive unready data-memory wait cycles before fault.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: id_rs1  input  3  source register 1 of the instruction in ID.
REQ-005 Port: id_rs2  input  3  source register 2 of the instruction in ID.
REQ-006 Port: id_ex_rd  input  3  destination register of the instruction in EX.
REQ-007 Port: id_ex_memread  input  1  the instruction in EX is a load.
REQ-008 Port: branch_taken  input  1  EX resolved a taken branch or jump this cycle.
REQ-009 Port: mem_req  input  1  the instruction in MEM is accessing data memory.
REQ-010 Port: mem_ready  input  1  data memory completes the access this cycle.
REQ-011 Port: wb_halt  input  1  a HALT instruction is in WB.
REQ-012 Port: pc_write, if_id_write, id_ex_write, ex_mem_write  output  1 each  stage-advance enables.
REQ-013 Port: if_id_flush, id_ex_flush  output  1 each  insert a bubble into that pipeline register.
REQ-014 Port: halted  output  1  the core is stopped.
REQ-015 Port: mem_timeout  output  1  sticky fault: the memory wait exceeded MEM_TIMEOUT.
REQ-016 Port: stall_cycles  output  16  saturating count of stalled cycles.

Function
REQ-017 FSM states: RUN, MEM_WAIT, HALTED; control outputs are combinational from state and inputs.
REQ-018 Load-use condition: id_ex_memread && id_ex_rd!=0 && (id_ex_rd==id_rs1 || id_ex_rd==id_rs2).
REQ-019 Advance decision, in priority order; evaluated in RUN, and in MEM_WAIT when mem_ready=1.
- (a) mem_req && !mem_ready: all four write enables 0, flushes 0; next state MEM_WAIT.
- (b) branch_taken: all write enables 1, if_id_flush=1, id_ex_flush=1; load-use is ignored.
- (c) load-use: pc_write=0, if_id_write=0, id_ex_flush=1, id_ex_write=1, ex_mem_write=1.
- (d) otherwise: all write enables 1, flushes 0.
REQ-020 MEM_WAIT with mem_ready=0: all enables 0, flushes 0; wait_cnt increments.
REQ-021 MEM_WAIT with mem_ready=1: outputs per REQ-019 rules (b)-(d); next state RUN; wait_cnt clears.
REQ-022 MEM_WAIT timeout: mem_ready=0 with wait_cnt==MEM_TIMEOUT-1 -> next state HALTED, and mem_timeout sets.
REQ-023 wb_halt in RUN or MEM_WAIT: next state HALTED, with precedence over all other transitions.
- The current cycle's outputs still follow REQ-019 and REQ-020.
REQ-024 HALTED: all enables 0, flushes 0, halted=1; exit only by rst.
REQ-025 stall_cycles: increments by 1 on each non-HALTED cycle with pc_write=0; holds at 16'hFFFF.
REQ-026 wait_cnt width: clog2(MEM_TIMEOUT)+1 bits; it never wraps.
REQ-027 Rules (a)-(d) do not depend on register-0 writes, except the rd!=0 term in the load-use condition.

Reset
REQ-028 rst=1 at a clock edge forces all of the following, overriding any in-flight wait or halt.
- state=RUN, wait_cnt=0, stall_cycles=0, mem_timeout=0, halted=0.
REQ-029 While in RUN after reset with no hazards, outputs are: all write enables 1, flushes 0.

Structure
REQ-030 The shared package holds the state enumeration, the MEM_TIMEOUT default and the register-index width (3).
REQ-031 The block has one sub-module, load_use_detect: combinational REQ-018 logic, output load_use.

Verification
REQ-032 Load-use: id_ex_memread=1, id_ex_rd=3, id_rs2=3.
- Required: pc_write=0, if_id_write=0, id_ex_flush=1 for one cycle.
- Required: stall_cycles 0->1.
REQ-033 Branch plus load-use: branch_taken=1 with load-use true.
- Required: if_id_flush=1, id_ex_flush=1, pc_write=1.
- Required: stall_cycles unchanged.
REQ-034 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1.
- Required: 3 cycles with all enables 0, then a RUN release cycle.
- Required: stall_cycles=3.
REQ-035 Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready held 0.
- Required: HALTED entered after 4 wait cycles, mem_timeout=1, halted=1.
- Required: rst clears all of these.
REQ-036 Halt and reset: wb_halt=1 in RUN -> halted=1 next cycle, with all enables 0 held.
- rst=1 during MEM_WAIT -> state RUN next cycle, with counters 0.
